// File: rtl/ped_event_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// ped_event_scheduler_pkg
//   Shared definitions for the pulse-event scheduler.
//   - default parameter values for the scheduler top
//   - FSM state encoding (IDLE=0, OFFER=1, GAP=2)
//   - wrap_inc(): modulo-n increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package ped_event_scheduler_pkg;

  localparam int DEF_N_SRC   = 32'sd4;
  localparam int DEF_PEND_W  = 32'sd2;
  localparam int DEF_GAP_CYC = 32'sd2;
  localparam int DEF_ID_W    = 32'sd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_e;

  // Returns (v + 1) mod n for 0 <= v < n.
  function automatic int wrap_inc(input int v, input int n);
    if ((v + 32'sd1) >= n) begin
      return 32'sd0;
    end else begin
      return v + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/ped_event_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// ped_event_scheduler_rr_pick
//   Combinational rotate-priority picker: grants the first requesting source
//   at or after ptr, wrapping from N_SRC-1 back to 0.
// Ports:
//   req       in  N_SRC  request vector, bit i = source i has pending work
//   ptr       in  ID_W   index with highest priority this cycle
//   gnt_valid out 1      some request is set
//   gnt_id    out ID_W   granted source index (0 when gnt_valid is 0)
// -----------------------------------------------------------------------------
module ped_event_scheduler_rr_pick
  import ped_event_scheduler_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id
);

  logic [ID_W-1:0] w_idx;
  logic            w_hit;

  // Walk the sources starting at ptr; the first requester found wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    w_idx     = ptr;
    w_hit     = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      w_hit     = !gnt_valid && req[w_idx];
      gnt_id    = w_hit ? w_idx : gnt_id;
      gnt_valid = gnt_valid | w_hit;
      w_idx     = ID_W'(wrap_inc(int'(w_idx), N_SRC));
    end
  end

endmodule

// File: rtl/ped_event_scheduler.sv
// -----------------------------------------------------------------------------
// ped_event_scheduler
//   Collects one-cycle edge pulses from N_SRC detectors, queues them per source
//   in saturating counters and serialises them round-robin onto a single
//   valid/ready command channel, with GAP_CYC idle cycles after each accept.
// Ports:
//   clk        in   1      system clock (rising edge)
//   reset      in   1      asynchronous active-low reset
//   ped_pulse  in   N_SRC  one-cycle edge pulses, bit i = source i
//   cmd_ready  in   1      consumer accepts when high with cmd_valid
//   cmd_valid  out  1      command offered
//   cmd_id     out  ID_W   source being offered (holds last grant when idle)
//   pend_any   out  1      any pending counter non-zero (registered)
//   ovf        out  N_SRC  sticky overflow per source
//   ovf_clr    in   1      synchronous clear of ovf (a same-cycle set wins)
// -----------------------------------------------------------------------------
module ped_event_scheduler
  import ped_event_scheduler_pkg::*;
#(
  parameter int N_SRC   = DEF_N_SRC,
  parameter int PEND_W  = DEF_PEND_W,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] ped_pulse,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic             pend_any,
  output logic [N_SRC-1:0] ovf,
  input  logic             ovf_clr
);

  localparam logic [PEND_W-1:0] CNT_MAX  = '1;
  localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1'b1);
  localparam bit                GAP_EN   = (GAP_CYC > 32'sd0);
  localparam int                GAP_W    = (GAP_CYC > 32'sd1) ? $clog2(GAP_CYC) : 32'sd1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_EN ? GAP_W'(GAP_CYC - 32'sd1) : '0;
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1'b1);

  logic [PEND_W-1:0] r_cnt [N_SRC];
  logic [N_SRC-1:0]  r_ovf;
  logic              r_pend_any;
  sched_state_e      r_state;
  logic              r_cmd_valid;
  logic [ID_W-1:0]   r_cmd_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [GAP_W-1:0]  r_gap;

  logic [PEND_W-1:0] w_cnt_nxt [N_SRC];
  logic [N_SRC-1:0]  w_req;
  logic [N_SRC-1:0]  w_dec;
  logic [N_SRC-1:0]  w_ovf_set;
  logic              w_pend_nxt;
  logic              w_accept;
  logic              w_gnt_valid;
  logic [ID_W-1:0]   w_gnt_id;

  assign w_accept  = (r_state == ST_OFFER) && r_cmd_valid && cmd_ready;

  assign cmd_valid = r_cmd_valid;
  assign cmd_id    = r_cmd_id;
  assign pend_any  = r_pend_any;
  assign ovf       = r_ovf;

  // Next-state pending counters: a pulse and an accept on the same source cancel.
  always_comb begin
    w_req      = '0;
    w_dec      = '0;
    w_ovf_set  = '0;
    w_pend_nxt = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      w_req[i]     = (r_cnt[i] != '0);
      w_dec[i]     = w_accept && (r_cmd_id == ID_W'(i));
      w_cnt_nxt[i] = r_cnt[i];
      if (ped_pulse[i] && !w_dec[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
      end else if (w_dec[i] && !ped_pulse[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
      w_pend_nxt = w_pend_nxt | (w_cnt_nxt[i] != '0);
    end
  end

  // Round-robin choice among sources with pending events.
  ped_event_scheduler_rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // Pending counters and the registered pend_any flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SRC; i++) begin
        r_cnt[i] <= '0;
      end
      r_pend_any <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_pend_any <= w_pend_nxt;
    end
  end

  // Sticky overflow flags; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= w_ovf_set | (ovf_clr ? '0 : r_ovf);
    end
  end

  // Command FSM: IDLE picks a source, OFFER holds it until accepted, GAP spaces commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_rr_ptr    <= '0;
      r_gap       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_cmd_id    <= w_gnt_id;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_OFFER;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OFFER: begin
          if (w_accept) begin
            r_cmd_valid <= 1'b0;
            r_rr_ptr    <= ID_W'(wrap_inc(int'(r_cmd_id), N_SRC));
            if (GAP_EN) begin
              r_gap   <= GAP_LOAD;
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_OFFER;
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap - GAP_ONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ped_event_scheduler
//   Self-checking bench: directed scenarios with literal expectations plus a
//   randomized phase, all watched every cycle by a behavioural queue model.
// -----------------------------------------------------------------------------
module tb_ped_event_scheduler;

  localparam int N    = 4;
  localparam int G    = 2;
  localparam int CMAX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ped_pulse;
  logic       cmd_ready;
  logic       ovf_clr;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       pend_any;
  logic [3:0] ovf;

  ped_event_scheduler #(
    .N_SRC(4), .PEND_W(2), .GAP_CYC(2), .ID_W(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ped_pulse (ped_pulse),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .pend_any  (pend_any),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: per-source event counts, one offered command at a time,
  // and a cooldown count of edges during which no new pick may happen.
  int       m_cnt [N];
  bit [3:0] m_ovf;
  bit       m_valid;
  int       m_id;
  int       m_ptr;
  int       m_cool;
  bit       m_pend;
  int       m_grants [$];
  int       dut_grants [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ovf = '0; m_valid = 0; m_id = 0; m_ptr = 0; m_cool = 0; m_pend = 0;
  endtask

  task automatic model_step();
    int       old [N];
    bit       acc;
    bit [3:0] set;
    bit       inc, dec;
    acc = m_valid && cmd_ready;
    set = '0;
    for (int i = 0; i < N; i++) begin
      old[i] = m_cnt[i];
      inc = ped_pulse[i];
      dec = acc && (m_id == i);
      if (inc && !dec) begin
        if (m_cnt[i] == CMAX) set[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (dec && !inc) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_ovf = set | (ovf_clr ? 4'b0000 : m_ovf);
    if (m_valid) begin
      if (acc) begin
        m_grants.push_back(m_id);
        m_valid = 0;
        m_cool  = G;
        m_ptr   = (m_id + 1) % N;
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!m_valid && old[(m_ptr + k) % N] != 0) begin
          m_valid = 1;
          m_id    = (m_ptr + k) % N;
        end
      end
    end
    m_pend = 0;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) m_pend = 1;
  endtask

  // Model advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_step();
  end

  // Compare process and DUT-side grant log, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (cmd_valid && cmd_ready) dut_grants.push_back(int'(cmd_id));
      if (chk_en) begin
        check("cmd_valid", int'(cmd_valid), int'(m_valid));
        check("pend_any", int'(pend_any), int'(m_pend));
        check("ovf", int'(ovf), int'(m_ovf));
        if (m_valid) check("cmd_id", int'(cmd_id), m_id);
      end
    end
  end

  // Drive inputs for one edge; returns 2 time units after that edge.
  task automatic step(input logic [3:0] p, input logic r, input logic c);
    ped_pulse = p; cmd_ready = r; ovf_clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic check_grants(input string name, input int g0, input int exp_q[$]);
    check({name, "_count"}, dut_grants.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i < dut_grants.size()) check({name, "_id"}, dut_grants[g0 + i], exp_q[i]);
    end
  endtask

  initial begin
    int       g0;
    int       pos;
    int       exp_q [$];
    logic [3:0] p;
    ped_pulse = '0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_cmd_id", int'(cmd_id), 0);
    check("rst_pend_any", int'(pend_any), 0);
    check("rst_ovf", int'(ovf), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    chk_en = 1'b1;

    // 1: single pulse on source 2, one-cycle latency, then gap and silence
    step(4'b0100, 1'b1, 1'b0);
    check("t1_pend_after_pulse", int'(pend_any), 1);
    check("t1_valid_after_pulse", int'(cmd_valid), 0);
    step(4'b0000, 1'b1, 1'b0);
    check("t1_valid", int'(cmd_valid), 1);
    check("t1_id", int'(cmd_id), 2);
    step(4'b0000, 1'b1, 1'b0);
    check("t1_valid_dropped", int'(cmd_valid), 0);
    check("t1_pend_dropped", int'(pend_any), 0);
    for (int k = 0; k < 6; k++) begin
      step(4'b0000, 1'b1, 1'b0);
      check("t1_quiet", int'(cmd_valid), 0);
    end

    // 2: three simultaneous pulses granted in index order from pointer 0
    do_reset();
    g0 = dut_grants.size();
    step(4'b1011, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(4'b0000, 1'b1, 1'b0);
    exp_q = '{0, 1, 3};
    check_grants("t2_order", g0, exp_q);
    check("t2_rr_ptr", int'(dut.r_rr_ptr), 0);
    check("t2_pend_any", int'(pend_any), 0);

    // 3: stalled consumer, counter saturation, sticky overflow and its clear
    do_reset();
    for (int k = 0; k < 10; k++) step((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
    check("t3_cnt_sat", int'(dut.r_cnt[1]), 3);
    check("t3_ovf_set", int'(ovf), 2);
    check("t3_id_frozen", int'(cmd_id), 1);
    check("t3_valid_held", int'(cmd_valid), 1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("t3_ovf_sticky", int'(ovf), 2);
    step(4'b0010, 1'b0, 1'b1);
    check("t3_set_beats_clr", int'(ovf), 2);
    step(4'b0000, 1'b0, 1'b1);
    check("t3_ovf_clr", int'(ovf), 0);
    g0 = dut_grants.size();
    for (int k = 0; k < 20; k++) step(4'b0000, 1'b1, 1'b0);
    exp_q = '{1, 1, 1};
    check_grants("t3_drain", g0, exp_q);

    // 4: pulse coinciding with the accept of the same source keeps count at 1
    do_reset();
    g0 = dut_grants.size();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    check("t4_valid_after_acc", int'(cmd_valid), 0);
    check("t4_pend", int'(pend_any), 1);
    check("t4_cnt", int'(dut.r_cnt[3]), 1);
    for (int k = 0; k < 10; k++) step(4'b0000, 1'b1, 1'b0);
    exp_q = '{3, 3};
    check_grants("t4_grants", g0, exp_q);

    // 5: asynchronous reset during OFFER clears everything at once
    do_reset();
    for (int k = 0; k < 4; k++) step(4'b0001, 1'b0, 1'b0);
    check("t5_pre_valid", int'(cmd_valid), 1);
    check("t5_pre_ovf", int'(ovf), 1);
    #1 reset = 1'b0;
    #1;
    check("t5_valid", int'(cmd_valid), 0);
    check("t5_pend", int'(pend_any), 0);
    check("t5_ovf", int'(ovf), 0);
    check("t5_cnt", int'(dut.r_cnt[0]), 0);
    check("t5_rr_ptr", int'(dut.r_rr_ptr), 0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    reset = 1'b1;
    g0 = dut_grants.size();
    for (int k = 0; k < 10; k++) step(4'b0000, 1'b1, 1'b0);
    check("t5_no_replay", dut_grants.size() - g0, 0);

    // 6: fairness against a source that pulses every cycle
    do_reset();
    g0 = dut_grants.size();
    step(4'b0101, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) step(4'b0001, 1'b1, 1'b0);
    pos = -1;
    for (int i = g0; i < dut_grants.size(); i++) begin
      if (pos < 0 && dut_grants[i] == 2) pos = i - g0;
    end
    check("t6_src2_within_2", int'(pos >= 0 && pos <= 1), 1);

    // randomized traffic, checked every cycle by the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      p = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      step(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end
    for (int k = 0; k < 30; k++) step(4'b0000, 1'b1, 1'b0);

    check("grant_total", dut_grants.size(), m_grants.size());
    for (int i = 0; i < m_grants.size(); i++) begin
      if (i < dut_grants.size()) check("grant_seq", dut_grants[i], m_grants[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
